qpu_itcm_icb_arbt: RTL and testbench

Two-to-one ICB arbiter in front of the ITCM controller. It shares the single ITCM ICB port between the IFU fetch path and the instruction loader. The loader is a host/DMA port that reads and writes program memory. The block tracks outstanding transactions so each in-order response returns to the requester that issued it. It also tells the IFU when the ITCM RAM output no longer holds the IFU's last fetched data.

---
 rtl/qpu_itcm_icb_arbt_pkg.sv | 16 +
 rtl/qpu_itcm_icb_arbt_if.sv | 33 +++
 rtl/qpu_itcm_icb_arbt_src_fifo.sv | 53 +++++
 rtl/qpu_itcm_icb_arbt.sv | 137 +++++++++++++
 tb/tb_qpu_itcm_icb_arbt.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpu_itcm_icb_arbt_pkg.sv
// Shared constants for the ITCM ICB arbiter: default bus widths,
// source-id encodings and the IFU write-mask constant.
package qpu_itcm_icb_arbt_pkg;

    localparam int ITCM_AW = 16;
    localparam int ITCM_DW = 64;
    localparam int ITCM_MW = ITCM_DW / 8;

    typedef enum logic {
        SRC_IFU = 1'b0,
        SRC_LDA = 1'b1
    } src_e;

    localparam logic [ITCM_MW-1:0] IFU_WMASK = '1;

endpackage

// File: rtl/qpu_itcm_icb_arbt_if.sv
// ICB command/response bundle with valid/ready handshakes.
// master: issues cmd_*, accepts rsp_*; slave: the opposite side.
interface qpu_itcm_icb_arbt_if
    import qpu_itcm_icb_arbt_pkg::*;
#(
    parameter int AW = ITCM_AW,
    parameter int DW = ITCM_DW,
    parameter int MW = ITCM_MW
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read,
        output cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read,
        input  cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/qpu_itcm_icb_arbt_src_fifo.sv
// Small synchronous FIFO holding the source id of each outstanding
// command. Ports: push/din, pop/dout (head), full, empty.
module qpu_arbt_src_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_idx] <= din;
                wr_idx      <= idx_inc(wr_idx);
            end
            if (do_pop) rd_idx <= idx_inc(rd_idx);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/qpu_itcm_icb_arbt.sv
// Two-to-one ICB arbiter sharing the ITCM port between IFU and loader.
// Ports: clk, rst_n, ifu/lda (slave), itcm (master), itcm_holdup,
// ifu_holdup, arbt_err. Optional macro: QPU_ITCM_ARBT_RR_EN.
module qpu_itcm_icb_arbt
    import qpu_itcm_icb_arbt_pkg::*;
#(
    parameter int AW         = ITCM_AW,
    parameter int DW         = ITCM_DW,
    parameter int MW         = ITCM_MW,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    qpu_itcm_icb_arbt_if.slave          ifu,
    qpu_itcm_icb_arbt_if.slave          lda,
    qpu_itcm_icb_arbt_if.master         itcm,
    input  logic                        itcm_holdup,
    output logic                        ifu_holdup,
    output logic                        arbt_err
);

    src_e          grant;
    src_e          lock_src;
    src_e          head_src;
    logic          lock_vld;
    logic          gnt_lda;
    logic          gnt_vld;
    logic          cmd_hs;
    logic          rsp_hs;
    logic          fifo_full;
    logic          fifo_empty;
    logic [0:0]    fifo_dout;
    logic          lda_touched;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          unused_ifu;

`ifdef QPU_ITCM_ARBT_RR_EN
    src_e          rr_last;
`endif

    // IFU commands are always reads; its write fields are ignored.
    assign unused_ifu = ^{ifu.cmd_read, ifu.cmd_wdata, ifu.cmd_wmask};

    always_comb begin
        grant = SRC_IFU;
        if (lock_vld)
            grant = lock_src;
`ifdef QPU_ITCM_ARBT_RR_EN
        else if (lda.cmd_valid & ifu.cmd_valid)
            grant = (rr_last == SRC_LDA) ? SRC_IFU : SRC_LDA;
`endif
        else if (lda.cmd_valid)
            grant = SRC_LDA;
    end

    assign gnt_lda   = (grant == SRC_LDA);
    assign gnt_vld   = gnt_lda ? lda.cmd_valid : ifu.cmd_valid;
    assign cmd_addr  = gnt_lda ? lda.cmd_addr : ifu.cmd_addr;
    assign cmd_wdata = gnt_lda ? lda.cmd_wdata : '0;
    assign cmd_wmask = gnt_lda ? lda.cmd_wmask : MW'(IFU_WMASK);

    // A full source FIFO blocks everything; a pop does not free a
    // slot until the following cycle.
    assign itcm.cmd_valid = gnt_vld & ~fifo_full;
    assign itcm.cmd_addr  = cmd_addr;
    assign itcm.cmd_read  = gnt_lda ? lda.cmd_read : 1'b1;
    assign itcm.cmd_wdata = cmd_wdata;
    assign itcm.cmd_wmask = cmd_wmask;
    assign ifu.cmd_ready  = ~gnt_lda & ~fifo_full & itcm.cmd_ready;
    assign lda.cmd_ready  = gnt_lda & ~fifo_full & itcm.cmd_ready;

    assign cmd_hs = itcm.cmd_valid & itcm.cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld <= 1'b0;
            lock_src <= SRC_IFU;
        end else begin
            lock_vld <= itcm.cmd_valid & ~itcm.cmd_ready;
            lock_src <= grant;
        end
    end

`ifdef QPU_ITCM_ARBT_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_last <= SRC_LDA;
        else if (cmd_hs)
            rr_last <= grant;
    end
`endif

    qpu_arbt_src_fifo #(
        .DEPTH (OUTS_DEPTH),
        .W     (1)
    ) u_src_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_hs),
        .din   (gnt_lda),
        .pop   (rsp_hs),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_src = src_e'(fifo_dout);

    // With nothing outstanding, responses are sunk and flagged.
    assign itcm.rsp_ready = fifo_empty ? 1'b1 :
                            (head_src == SRC_LDA) ? lda.rsp_ready :
                                                    ifu.rsp_ready;
    assign ifu.rsp_valid  = itcm.rsp_valid & ~fifo_empty &
                            (head_src == SRC_IFU);
    assign lda.rsp_valid  = itcm.rsp_valid & ~fifo_empty &
                            (head_src == SRC_LDA);
    assign ifu.rsp_rdata  = itcm.rsp_rdata;
    assign lda.rsp_rdata  = itcm.rsp_rdata;

    assign rsp_hs = itcm.rsp_valid & itcm.rsp_ready & ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arbt_err    <= 1'b0;
            lda_touched <= 1'b0;
        end else begin
            if (itcm.rsp_valid & fifo_empty) arbt_err <= 1'b1;
            if (cmd_hs) lda_touched <= gnt_lda;
        end
    end

    // Any loader access may have changed the RAM output the IFU saw.
    assign ifu_holdup = itcm_holdup & ~lda_touched;

endmodule

// File: tb/tb_qpu_itcm_icb_arbt.sv
// Self-checking bench for qpu_itcm_icb_arbt with an ITCM responder
// model and an in-order response scoreboard.
module tb_qpu_itcm_icb_arbt;

`ifdef QPU_ITCM_ARBT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic itcm_holdup;
    logic ifu_holdup;
    logic arbt_err;
    logic spur;
    logic rsp_hold;
    logic rv_q;
    logic [63:0] rd_q;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qpu_itcm_icb_arbt_if ifu_if ();
    qpu_itcm_icb_arbt_if lda_if ();
    qpu_itcm_icb_arbt_if itcm_if ();

    qpu_itcm_icb_arbt #(
        .AW (16), .DW (64), .MW (8), .OUTS_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifu         (ifu_if),
        .lda         (lda_if),
        .itcm        (itcm_if),
        .itcm_holdup (itcm_holdup),
        .ifu_holdup  (ifu_holdup),
        .arbt_err    (arbt_err)
    );

    function automatic logic [63:0] mem_data(input logic [15:0] a);
        return {48'hC0DE_1234_5678, a};
    endfunction

    // ITCM model: one-cycle read latency, in order, can be held off.
    logic [15:0] pend[$];
    assign itcm_if.rsp_valid = rv_q | spur;
    assign itcm_if.rsp_rdata = rd_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            rv_q <= 1'b0;
            rd_q <= '0;
        end else begin
            if (rv_q && itcm_if.rsp_ready) void'(pend.pop_front());
            if (itcm_if.cmd_valid && itcm_if.cmd_ready)
                pend.push_back(itcm_if.cmd_addr);
            if (!rsp_hold && pend.size() > 0) begin
                rv_q <= 1'b1;
                rd_q <= mem_data(pend[0]);
            end else begin
                rv_q <= 1'b0;
                rd_q <= '0;
            end
        end
    end

    typedef struct {
        bit          lda;
        bit          rd;
        logic [15:0] a;
    } sb_t;

    sb_t sb[$];
    sb_t e;

    always @(posedge clk) begin
        if (rst_n) begin
            if (ifu_if.cmd_valid && ifu_if.cmd_ready)
                sb.push_back('{1'b0, 1'b1, ifu_if.cmd_addr});
            if (lda_if.cmd_valid && lda_if.cmd_ready)
                sb.push_back('{1'b1, lda_if.cmd_read, lda_if.cmd_addr});
            if (ifu_if.rsp_valid && ifu_if.rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $error("FAIL ifu_rsp_unexpected got=1 want=0");
                end else begin
                    e = sb.pop_front();
                    assert (!e.lda && ifu_if.rsp_rdata === mem_data(e.a))
                    else begin
                        failures++;
                        $error("FAIL ifu_rsp src_lda=%0d rdata=%h want=%h",
                               e.lda, ifu_if.rsp_rdata, mem_data(e.a));
                    end
                end
            end
            if (lda_if.rsp_valid && lda_if.rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $error("FAIL lda_rsp_unexpected got=1 want=0");
                end else begin
                    e = sb.pop_front();
                    assert (e.lda &&
                            (!e.rd || lda_if.rsp_rdata === mem_data(e.a)))
                    else begin
                        failures++;
                        $error("FAIL lda_rsp src_lda=%0d rdata=%h want=%h",
                               e.lda, lda_if.rsp_rdata, mem_data(e.a));
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input bit is_lda, input string tag);
        int n = 0;
        @(negedge clk);
        while (!(is_lda ? lda_if.cmd_ready : ifu_if.cmd_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 20) else begin
            failures++;
            $error("FAIL %s cycles=%0d limit=20", tag, n);
        end
        nxt();
    endtask

    task automatic ifu_cmd(input logic [15:0] a);
        ifu_if.cmd_valid = 1'b1;
        ifu_if.cmd_addr  = a;
        wait_hs(1'b0, "ifu_hs_timeout");
        ifu_if.cmd_valid = 1'b0;
    endtask

    task automatic lda_cmd(input logic [15:0] a, input bit rd,
                           input logic [63:0] wd, input logic [7:0] wm);
        lda_if.cmd_valid = 1'b1;
        lda_if.cmd_addr  = a;
        lda_if.cmd_read  = rd;
        lda_if.cmd_wdata = wd;
        lda_if.cmd_wmask = wm;
        wait_hs(1'b1, "lda_hs_timeout");
        lda_if.cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            nxt();
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL %s pending=%0d want=0", tag, sb.size());
        end
        nxt();
    endtask

    initial begin
        rst_n = 1'b0;
        itcm_holdup = 1'b1;
        spur = 1'b0;
        rsp_hold = 1'b0;
        ifu_if.cmd_valid = 1'b0;
        ifu_if.cmd_addr  = '0;
        ifu_if.cmd_read  = 1'b1;
        ifu_if.cmd_wdata = '0;
        ifu_if.cmd_wmask = '1;
        ifu_if.rsp_ready = 1'b1;
        lda_if.cmd_valid = 1'b0;
        lda_if.cmd_addr  = '0;
        lda_if.cmd_read  = 1'b1;
        lda_if.cmd_wdata = '0;
        lda_if.cmd_wmask = '0;
        lda_if.rsp_ready = 1'b1;
        itcm_if.cmd_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", itcm_if.cmd_valid, 0);
        chk("rst_ifu_rsp", ifu_if.rsp_valid, 0);
        chk("rst_lda_rsp", lda_if.rsp_valid, 0);
        chk("rst_err", arbt_err, 0);
        chk("rst_holdup", ifu_holdup, 1);
        nxt();
        rst_n = 1'b1;
        nxt();

        // contention in the same cycle
        ifu_if.cmd_valid = 1'b1;
        ifu_if.cmd_addr  = 16'h0020;
        lda_if.cmd_valid = 1'b1;
        lda_if.cmd_read  = 1'b1;
        lda_if.cmd_addr  = 16'h0030;
        @(negedge clk);
        chk("c2_lda_first", lda_if.cmd_ready, !RR);
        chk("c2_ifu_first", ifu_if.cmd_ready, RR);
        chk("c2_addr", itcm_if.cmd_addr, RR ? 16'h0020 : 16'h0030);
        nxt();
        if (RR) ifu_if.cmd_valid = 1'b0;
        else    lda_if.cmd_valid = 1'b0;
        @(negedge clk);
        chk("c2_lda_second", lda_if.cmd_ready, RR);
        chk("c2_ifu_second", ifu_if.cmd_ready, !RR);
        nxt();
        ifu_if.cmd_valid = 1'b0;
        lda_if.cmd_valid = 1'b0;
        drain("c2_drain");

        // IFU-only back-to-back reads
        for (int i = 0; i < 4; i++) ifu_cmd(16'(i * 8));
        @(negedge clk);
        chk("c1_lda_rsp", lda_if.rsp_valid, 0);
        chk("c1_holdup_hi", ifu_holdup, 1);
        itcm_holdup = 1'b0;
        #1;
        chk("c1_holdup_lo", ifu_holdup, 0);
        itcm_holdup = 1'b1;
        nxt();
        drain("c1_drain");

        // grant lock while the ITCM stalls
        itcm_if.cmd_ready = 1'b0;
        ifu_if.cmd_valid  = 1'b1;
        ifu_if.cmd_addr   = 16'h0050;
        @(negedge clk);
        chk("c3_valid", itcm_if.cmd_valid, 1);
        chk("c3_addr0", itcm_if.cmd_addr, 16'h0050);
        nxt();
        lda_if.cmd_valid = 1'b1;
        lda_if.cmd_read  = 1'b0;
        lda_if.cmd_addr  = 16'h0060;
        lda_if.cmd_wdata = 64'h1122_3344_5566_7788;
        lda_if.cmd_wmask = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("c3_lock_addr", itcm_if.cmd_addr, 16'h0050);
            chk("c3_lda_blocked", lda_if.cmd_ready, 0);
            nxt();
        end
        itcm_if.cmd_ready = 1'b1;
        @(negedge clk);
        chk("c3_ifu_rdy", ifu_if.cmd_ready, 1);
        chk("c3_ifu_read", itcm_if.cmd_read, 1);
        chk("c3_ifu_wmask", itcm_if.cmd_wmask, 8'hFF);
        chk("c3_ifu_wdata", itcm_if.cmd_wdata, 0);
        nxt();
        ifu_if.cmd_valid = 1'b0;
        @(negedge clk);
        chk("c3_lda_rdy", lda_if.cmd_ready, 1);
        chk("c3_lda_read", itcm_if.cmd_read, 0);
        chk("c3_lda_wmask", itcm_if.cmd_wmask, 8'h0F);
        chk("c3_lda_wdata", itcm_if.cmd_wdata, 64'h1122_3344_5566_7788);
        chk("c3_lda_addr", itcm_if.cmd_addr, 16'h0060);
        nxt();
        lda_if.cmd_valid = 1'b0;
        drain("c3_drain");

        // holdup kill by a loader write
        ifu_cmd(16'h0070);
        @(negedge clk);
        chk("c5_hold_ifu", ifu_holdup, 1);
        nxt();
        lda_cmd(16'h0040, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        @(negedge clk);
        chk("c5_hold_killed", ifu_holdup, 0);
        nxt();
        ifu_cmd(16'h0078);
        @(negedge clk);
        chk("c5_hold_back", ifu_holdup, 1);
        nxt();
        drain("c5_drain");

        // full source FIFO, no pop bypass
        rsp_hold = 1'b1;
        nxt();
        ifu_cmd(16'h0080);
        ifu_cmd(16'h0088);
        ifu_if.cmd_valid = 1'b1;
        ifu_if.cmd_addr  = 16'h0090;
        @(negedge clk);
        chk("c4_full_rdy", ifu_if.cmd_ready, 0);
        chk("c4_full_valid", itcm_if.cmd_valid, 0);
        nxt();
        rsp_hold = 1'b0;
        @(negedge clk);
        chk("c4_still_full", ifu_if.cmd_ready, 0);
        nxt();
        @(negedge clk);
        chk("c4_rsp_valid", ifu_if.rsp_valid, 1);
        chk("c4_no_bypass", ifu_if.cmd_ready, 0);
        nxt();
        @(negedge clk);
        chk("c4_accept", ifu_if.cmd_ready, 1);
        nxt();
        ifu_if.cmd_valid = 1'b0;
        drain("c4_drain");

        // spurious response with nothing outstanding
        spur = 1'b1;
        @(negedge clk);
        chk("c6_rsp_ready", itcm_if.rsp_ready, 1);
        chk("c6_ifu_rsp", ifu_if.rsp_valid, 0);
        chk("c6_lda_rsp", lda_if.rsp_valid, 0);
        nxt();
        spur = 1'b0;
        @(negedge clk);
        chk("c6_err_set", arbt_err, 1);
        repeat (3) nxt();
        @(negedge clk);
        chk("c6_err_sticky", arbt_err, 1);
        nxt();
        rst_n = 1'b0;
        @(negedge clk);
        chk("c6_err_rst", arbt_err, 0);
        nxt();
        rst_n = 1'b1;
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
